// File: rtl/counter_preset_checker.sv
// Cycle-accurate reference model and checker for a presettable up-counter DUT.
// Latency: model tracks commands one edge later; mismatch pulses one edge after the differing cycle.
// No backpressure (pure monitor). Optional first-mismatch capture: COUNTER_CHECKER_CAPTURE_EN.
module counter_preset_checker #(
    parameter int WIDTH   = 8,
    parameter int MAX_ERR = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             chk_en,
    input  logic             count_up,
    input  logic             load,
    input  logic [WIDTH-1:0] data_preset,
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] exp_count,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [15:0]      err_cnt,
    output logic [15:0]      chk_cnt,
    output logic             halted,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_obs
);

    typedef enum logic [1:0] {IDLE, CHECK, HALT} state_t;

    localparam logic [15:0] MAX_ERR_C = 16'(MAX_ERR);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] exp_count_q, exp_count_d;
    logic             mismatch_q, mismatch_d;
    logic             err_sticky_q, err_sticky_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic [15:0]      chk_cnt_q, chk_cnt_d;
    logic             halted_q, halted_d;
    logic             diff;

    assign diff = (count != exp_count_q);

    always_comb begin
        state_d      = state_q;
        exp_count_d  = exp_count_q;
        mismatch_d   = 1'b0;
        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;
        chk_cnt_d    = chk_cnt_q;

        // Model runs in every state so it never drifts from the DUT.
        if (load) begin
            exp_count_d = data_preset;
        end else if (count_up) begin
            exp_count_d = exp_count_q + WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (chk_en) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (chk_cnt_q != 16'hFFFF) begin
                    chk_cnt_d = chk_cnt_q + 16'd1;
                end
                if (diff) begin
                    mismatch_d   = 1'b1;
                    err_sticky_d = 1'b1;
                    err_cnt_d    = err_cnt_q + 16'd1;
                end
                // Reaching the error limit wins over a simultaneous disable.
                if (diff && (err_cnt_q + 16'd1 == MAX_ERR_C)) begin
                    state_d = HALT;
                end else if (!chk_en) begin
                    state_d = IDLE;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            exp_count_q  <= '0;
            mismatch_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
            chk_cnt_q    <= '0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_count_q  <= exp_count_d;
            mismatch_q   <= mismatch_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
            chk_cnt_q    <= chk_cnt_d;
            halted_q     <= halted_d;
        end
    end

`ifdef COUNTER_CHECKER_CAPTURE_EN
    logic [WIDTH-1:0] first_exp_q, first_exp_d;
    logic [WIDTH-1:0] first_obs_q, first_obs_d;

    // Snapshot only the very first mismatch; later ones leave it frozen.
    always_comb begin
        first_exp_d = first_exp_q;
        first_obs_d = first_obs_q;
        if ((state_q == CHECK) && diff && !err_sticky_q) begin
            first_exp_d = exp_count_q;
            first_obs_d = count;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_exp_q <= '0;
            first_obs_q <= '0;
        end else begin
            first_exp_q <= first_exp_d;
            first_obs_q <= first_obs_d;
        end
    end

    assign first_exp = first_exp_q;
    assign first_obs = first_obs_q;
`else
    assign first_exp = '0;
    assign first_obs = '0;
`endif

    assign exp_count  = exp_count_q;
    assign mismatch   = mismatch_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;
    assign chk_cnt    = chk_cnt_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_counter_preset_checker.sv
// Bench for counter_preset_checker: behavioural counter DUT with fault modes, scoreboard of expected outputs.
module tb_counter_preset_checker;

    localparam int W  = 8;
    localparam int ME = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         chk_en = 1'b0;
    logic         count_up = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] data_preset = '0;
    logic [W-1:0] count;
    logic [W-1:0] exp_count;
    logic         mismatch;
    logic         err_sticky;
    logic [15:0]  err_cnt;
    logic [15:0]  chk_cnt;
    logic         halted;
    logic [W-1:0] first_exp;
    logic [W-1:0] first_obs;

    counter_preset_checker #(.WIDTH(W), .MAX_ERR(ME)) dut (
        .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .count_up(count_up),
        .load(load), .data_preset(data_preset), .count(count),
        .exp_count(exp_count), .mismatch(mismatch), .err_sticky(err_sticky),
        .err_cnt(err_cnt), .chk_cnt(chk_cnt), .halted(halted),
        .first_exp(first_exp), .first_obs(first_obs)
    );

    always #5 clk = ~clk;

    // Counter under observation: 0 = correct, 1 = saturates at all-ones, 2 = output stuck at 0.
    int           fault = 0;
    logic [W-1:0] tb_cnt = '0;
    assign count = (fault == 2) ? '0 : tb_cnt;

    typedef struct {
        logic [W-1:0] exp_count;
        logic         mismatch;
        logic         err_sticky;
        logic [15:0]  err_cnt;
        logic [15:0]  chk_cnt;
        logic         halted;
        logic [W-1:0] first_exp;
        logic [W-1:0] first_obs;
    } exp_t;

    typedef struct {
        logic         ld;
        logic         up;
        logic [W-1:0] pre;
        logic         en;
        logic [W-1:0] exp;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];

    // Bench-side reference: 0 idle, 1 checking, 2 halted.
    int           m_state = 0;
    logic [W-1:0] m_exp = '0;
    logic [15:0]  m_err = '0;
    logic [15:0]  m_chk = '0;
    logic         m_sticky = 1'b0;
    logic [W-1:0] m_fexp = '0;
    logic [W-1:0] m_fobs = '0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
            e = sb.pop_front();
            chk("exp_count", 32'(exp_count), 32'(e.exp_count));
            chk("mismatch", 32'(mismatch), 32'(e.mismatch));
            chk("err_sticky", 32'(err_sticky), 32'(e.err_sticky));
            chk("err_cnt", 32'(err_cnt), 32'(e.err_cnt));
            chk("chk_cnt", 32'(chk_cnt), 32'(e.chk_cnt));
            chk("halted", 32'(halted), 32'(e.halted));
            chk("first_exp", 32'(first_exp), 32'(e.first_exp));
            chk("first_obs", 32'(first_obs), 32'(e.first_obs));
        end
    endtask

    task automatic step(input logic ld, input logic up, input logic [W-1:0] pre, input logic en);
        exp_t         e;
        logic [W-1:0] nexp;
        @(negedge clk);
        load = ld;
        count_up = up;
        data_preset = pre;
        chk_en = en;
        nexp = ld ? pre : (up ? m_exp + 8'd1 : m_exp);
        e.mismatch = 1'b0;
        if (m_state == 1) begin
            if (m_chk != 16'hFFFF) m_chk = m_chk + 16'd1;
            if (count != m_exp) begin
                e.mismatch = 1'b1;
`ifdef COUNTER_CHECKER_CAPTURE_EN
                if (!m_sticky) begin
                    m_fexp = m_exp;
                    m_fobs = count;
                end
`endif
                m_sticky = 1'b1;
                m_err = m_err + 16'd1;
            end
            if (e.mismatch && m_err == 16'(ME)) m_state = 2;
            else if (!en) m_state = 0;
        end else if (m_state == 0 && en) begin
            m_state = 1;
        end
        m_exp = nexp;
        e.exp_count  = m_exp;
        e.err_sticky = m_sticky;
        e.err_cnt    = m_err;
        e.chk_cnt    = m_chk;
        e.halted     = (m_state == 2);
        e.first_exp  = m_fexp;
        e.first_obs  = m_fobs;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (ld) tb_cnt = pre;
        else if (up && !(fault == 1 && tb_cnt == 8'hFF)) tb_cnt = tb_cnt + 8'd1;
        compare_out();
    endtask

    task automatic do_reset(input int new_fault);
        #2;
        rst_n = 1'b0;
        load = 1'b0;
        count_up = 1'b0;
        chk_en = 1'b0;
        #1;
        chk("rst_exp_count", 32'(exp_count), 0);
        chk("rst_mismatch", 32'(mismatch), 0);
        chk("rst_err_sticky", 32'(err_sticky), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_chk_cnt", 32'(chk_cnt), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_first_exp", 32'(first_exp), 0);
        chk("rst_first_obs", 32'(first_obs), 0);
        fault = new_fault;
        tb_cnt = '0;
        m_state = 0;
        m_exp = '0;
        m_err = '0;
        m_chk = '0;
        m_sticky = 1'b0;
        m_fexp = '0;
        m_fobs = '0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic void add(input logic ld, input logic up, input logic [W-1:0] pre,
                                input logic en, input logic [W-1:0] exp);
        vec_t v;
        v.ld = ld; v.up = up; v.pre = pre; v.en = en; v.exp = exp;
        tbl.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Enable one cycle ahead so the 20 counting edges are all compared.
        add(0, 0, 0, 1, 0);
        for (int i = 1; i <= 20; i++) add(0, 1, 0, 1, 8'(i));
        add(1, 0, 13, 1, 13);
        for (int i = 14; i <= 18; i++) add(0, 1, 0, 1, 8'(i));
        add(1, 1, 200, 1, 200);
        add(1, 0, 250, 1, 250);
        for (int i = 251; i <= 255; i++) add(0, 1, 8'(i), 1, 8'(i));
        add(0, 1, 0, 1, 0);

        do_reset(0);
        foreach (tbl[i]) begin
            step(tbl[i].ld, tbl[i].up, tbl[i].pre, tbl[i].en);
            chk("tbl_exp_count", 32'(exp_count), 32'(tbl[i].exp));
            if (i == 20) begin
                chk("run20_chk_cnt", 32'(chk_cnt), 20);
                chk("run20_err_cnt", 32'(err_cnt), 0);
                chk("run20_err_sticky", 32'(err_sticky), 0);
            end
        end
        chk("tbl_no_errors", 32'(err_cnt), 0);

        // Saturating DUT at the wrap point.
        do_reset(1);
        step(0, 0, 0, 1);
        step(1, 0, 255, 1);
        step(0, 1, 0, 1);
        chk("wrap_exp_count", 32'(exp_count), 0);
        step(1, 0, 5, 1);
        chk("sat_mismatch", 32'(mismatch), 1);
        chk("sat_err_cnt", 32'(err_cnt), 1);
`ifdef COUNTER_CHECKER_CAPTURE_EN
        chk("sat_first_exp", 32'(first_exp), 0);
        chk("sat_first_obs", 32'(first_obs), 255);
`else
        chk("sat_first_obs", 32'(first_obs), 0);
`endif
        step(0, 0, 0, 1);
        chk("sat_mismatch_clear", 32'(mismatch), 0);
        chk("sat_err_hold", 32'(err_cnt), 1);

        // Stuck-at-zero DUT runs into the error limit.
        do_reset(2);
        step(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 1);
        chk("halt_err_cnt", 32'(err_cnt), ME);
        chk("halt_halted", 32'(halted), 1);
        chk("halt_mismatch", 32'(mismatch), 0);
        chk("halt_exp_tracks", 32'(exp_count), 8);

        // Reset in the middle of a count.
        do_reset(0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 1);
        chk("mid_exp_count", 32'(exp_count), 7);
        do_reset(0);
        step(0, 1, 0, 1);
        chk("post_rst_idle_chk_cnt", 32'(chk_cnt), 0);
        step(0, 1, 0, 1);
        chk("post_rst_check_chk_cnt", 32'(chk_cnt), 1);
        chk("post_rst_exp_count", 32'(exp_count), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
